// File: rtl/ibis_tmds_decoder.sv
// rtl/ibis_tmds_decoder.sv - TMDS receive decoder with control-token word alignment and bitslip request.
// Optional disparity error counter: define IBIS_TMDS_DECODER_ERROR_COUNT_EN.
module ibis_tmds_decoder #(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_SETTLE   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] in_parallel,
`ifdef IBIS_TMDS_DECODER_ERROR_COUNT_EN
  input  logic        error_clear,
  output logic [15:0] error_count,
`endif
  output logic [7:0] data,
  output logic       data_enable,
  output logic [1:0] control,
  output logic       aligned,
  output logic       bitslip,
  output logic [1:0] debug_state
);

  localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);

  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_TOKENS);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_TOKENS - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [WIN_W-1:0]  win_cnt, win_nxt;
  logic [SET_W-1:0]  set_cnt, set_nxt;
  logic              slip_nxt;
  logic              is_token;
  logic [1:0]        tok_ctl;
  logic [7:0]        dec_d;
  logic [7:0]        dec_byte;
  logic              qualify;

  always_comb begin
    is_token = 1'b1;
    tok_ctl  = 2'b00;
    case (in_parallel)
      10'b1101010100: tok_ctl = 2'b00;
      10'b0010101011: tok_ctl = 2'b01;
      10'b0101010100: tok_ctl = 2'b10;
      10'b1010101011: tok_ctl = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    dec_d       = in_parallel[9] ? ~in_parallel[7:0] : in_parallel[7:0];
    dec_byte    = 8'h00;
    dec_byte[0] = dec_d[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = in_parallel[8] ? (dec_d[i] ^ dec_d[i-1]) : ~(dec_d[i] ^ dec_d[i-1]);
    end
  end

  // A run qualifies only on the word that brings the count up to LOCK_TOKENS.
  assign qualify = is_token && (state != ST_SETTLE) && (run_cnt == RUN_LAST);

  always_comb begin
    state_nxt = state;
    win_nxt   = win_cnt + 1'b1;
    set_nxt   = '0;
    slip_nxt  = 1'b0;
    if (state == ST_SETTLE) begin
      run_nxt = '0;
    end else if (is_token) begin
      run_nxt = (run_cnt == RUN_FULL) ? RUN_FULL : run_cnt + 1'b1;
    end else begin
      run_nxt = '0;
    end
    case (state)
      ST_SEARCH: begin
        if (qualify) begin
          state_nxt = ST_LOCKED;
          win_nxt   = '0;
        end else if (win_cnt == WIN_LAST) begin
          state_nxt = ST_SETTLE;
          win_nxt   = '0;
          run_nxt   = '0;
          slip_nxt  = 1'b1;
        end
      end
      ST_SETTLE: begin
        win_nxt = '0;
        if (set_cnt == SET_LAST) begin
          state_nxt = ST_SEARCH;
        end else begin
          set_nxt = set_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (qualify) begin
          win_nxt = '0;
        end else if (win_cnt == WIN_LAST) begin
          state_nxt = ST_SEARCH;
          win_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        win_nxt   = '0;
        run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_SEARCH;
      run_cnt     <= '0;
      win_cnt     <= '0;
      set_cnt     <= '0;
      bitslip     <= 1'b0;
      data        <= 8'h00;
      data_enable <= 1'b0;
      control     <= 2'b00;
    end else begin
      bitslip <= enable & slip_nxt;
      if (enable) begin
        state   <= state_nxt;
        run_cnt <= run_nxt;
        win_cnt <= win_nxt;
        set_cnt <= set_nxt;
        if (is_token) begin
          data_enable <= 1'b0;
          control     <= tok_ctl;
        end else begin
          data_enable <= 1'b1;
          data        <= dec_byte;
        end
      end
    end
  end

  assign aligned     = (state == ST_LOCKED);
  assign debug_state = state;

`ifdef IBIS_TMDS_DECODER_ERROR_COUNT_EN
  logic signed [4:0] run_disp;
  logic signed [4:0] disp_sat;
  logic [15:0]       err_cnt;
  logic              disp_err;
  int                disp_sum;

  always_comb begin
    disp_sum = int'(run_disp) + 2 * $countones(in_parallel) - 10;
    disp_err = (disp_sum > 8) || (disp_sum < -8);
    if (disp_sum > 15) begin
      disp_sat = 5'(15);
    end else if (disp_sum < -16) begin
      disp_sat = 5'(-16);
    end else begin
      disp_sat = 5'(disp_sum);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_disp <= '0;
      err_cnt  <= 16'h0000;
    end else if (enable) begin
      run_disp <= is_token ? 5'sd0 : disp_sat;
      if (error_clear) begin
        err_cnt <= 16'h0000;
      end else if (!is_token && (state == ST_LOCKED) && disp_err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign error_count = err_cnt;
`endif

endmodule

// File: tb/tb_ibis_tmds_decoder.sv
// tb/tb_ibis_tmds_decoder.sv - directed bench for ibis_tmds_decoder with a byte-level reference model.
module tb_ibis_tmds_decoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_a, en_a, reset_b, en_b;
  logic [9:0] in_a, in_b;
  logic [7:0] data_a, data_b;
  logic       de_a, de_b, aligned_a, aligned_b, slip_a, slip_b;
  logic [1:0] ctl_a, ctl_b, dbg_a, dbg_b;
`ifdef IBIS_TMDS_DECODER_ERROR_COUNT_EN
  logic        err_clr = 1'b0;
  logic [15:0] err_a, err_b;
`endif

  ibis_tmds_decoder #(.LOCK_TOKENS(8), .SEARCH_WINDOW(4096), .SLIP_SETTLE(16)) dut_a (
    .clock(clock), .reset(reset_a), .enable(en_a), .in_parallel(in_a),
`ifdef IBIS_TMDS_DECODER_ERROR_COUNT_EN
    .error_clear(err_clr), .error_count(err_a),
`endif
    .data(data_a), .data_enable(de_a), .control(ctl_a), .aligned(aligned_a),
    .bitslip(slip_a), .debug_state(dbg_a)
  );

  ibis_tmds_decoder #(.LOCK_TOKENS(8), .SEARCH_WINDOW(64), .SLIP_SETTLE(4)) dut_b (
    .clock(clock), .reset(reset_b), .enable(en_b), .in_parallel(in_b),
`ifdef IBIS_TMDS_DECODER_ERROR_COUNT_EN
    .error_clear(err_clr), .error_count(err_b),
`endif
    .data(data_b), .data_enable(de_b), .control(ctl_b), .aligned(aligned_b),
    .bitslip(slip_b), .debug_state(dbg_b)
  );

  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  int tests = 0;
  int fails = 0;
  int enc_cnt = 0;
  logic on_a = 1'b0;
  logic on_b = 1'b0;
  logic [10:0] exp_a, exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {data_enable, control, data} after one enabled symbol.
  function automatic logic [10:0] ref_out(input logic [9:0] s, input logic [10:0] prev);
    logic [7:0] qm;
    for (int c = 0; c < 4; c++) begin
      if (s == tok[c]) return {1'b0, 2'(c), prev[7:0]};
    end
    qm = s[9] ? ~s[7:0] : s[7:0];
    return {1'b1, prev[9:8], (qm ^ {qm[6:0], 1'b0}) ^ (s[8] ? 8'h00 : 8'hFE)};
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] v, input int n);
    return (v << n) | (v >> (10 - n));
  endfunction

  // Standard DVI TMDS encoder, used to generate loopback stimulus.
  task automatic encode(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += n1q - n0q - (qm[8] ? 0 : 2);
    end
  endtask

  always @(posedge clock) begin
    if (reset_a) exp_a <= '0;
    else if (en_a) exp_a <= ref_out(in_a, exp_a);
    if (reset_b) exp_b <= '0;
    else if (en_b) exp_b <= ref_out(in_b, exp_b);
  end

  always @(negedge clock) begin
    if (on_a) begin
      check("a_data", 32'(data_a), 32'(exp_a[7:0]));
      check("a_de", 32'(de_a), 32'(exp_a[10]));
      check("a_ctl", 32'(ctl_a), 32'(exp_a[9:8]));
    end
    if (on_b) begin
      check("b_data", 32'(data_b), 32'(exp_b[7:0]));
      check("b_de", 32'(de_b), 32'(exp_b[10]));
      check("b_ctl", 32'(ctl_b), 32'(exp_b[9:8]));
    end
  end

  task automatic step_a(input logic [9:0] s, input logic e);
    in_a = s;
    en_a = e;
    @(negedge clock);
  endtask

  task automatic step_b(input logic [9:0] s, input logic e);
    in_b = s;
    en_b = e;
    @(negedge clock);
  endtask

  initial begin
    logic [9:0] q;
    int drops, slips, lockw, early, r;
    int sw [3];
    reset_a = 1'b1; reset_b = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(negedge clock);
    on_a = 1'b1; on_b = 1'b1;
    check("rst_data", 32'(data_a), 0);
    check("rst_de", 32'(de_a), 0);
    check("rst_ctl", 32'(ctl_a), 0);
    check("rst_aligned", 32'(aligned_a), 0);
    check("rst_bitslip", 32'(slip_a), 0);
    check("rst_state", 32'(dbg_a), 0);
    reset_a = 1'b0;

    // Lock on 12 tokens of control 00: aligned from the 8th token.
    for (int k = 1; k <= 12; k++) begin
      step_a(tok[0], 1'b1);
      check("lock_aligned", 32'(aligned_a), 32'(k >= 8));
      check("lock_noslip", 32'(slip_a), 0);
    end
    check("lock_state", 32'(dbg_a), 2);

    // Hand-decoded literals.
    step_a(10'b0100000000, 1'b1);
    check("lit_100_data", 32'(data_a), 32'h00);
    check("lit_100_de", 32'(de_a), 1);
    step_a(10'b1111111111, 1'b1);
    check("lit_3ff_data", 32'(data_a), 32'h00);
    step_a(10'b1011111111, 1'b1);
    check("lit_2ff_data", 32'(data_a), 32'hFE);
    step_a(10'b0100000001, 1'b1);
    check("lit_101_data", 32'(data_a), 32'h03);
    check("lit_101_ctl_hold", 32'(ctl_a), 0);
    step_a(tok[3], 1'b1);
    check("lit_tok3_ctl", 32'(ctl_a), 3);
    check("lit_tok3_de", 32'(de_a), 0);
    check("lit_tok3_data_hold", 32'(data_a), 32'h03);

    // Encoder loopback: ramp framed by each control token.
    drops = 0;
    for (int c = 0; c < 4; c++) begin
      enc_cnt = 0;
      repeat (64) begin
        step_a(tok[c], 1'b1);
        if (!aligned_a) drops++;
      end
      check("loop_ctl", 32'(ctl_a), 32'(c));
      for (int b = 0; b < 256; b++) begin
        encode(8'(b), q);
        step_a(q, 1'b1);
        check("loop_byte", 32'(data_a), 32'(b));
        if (!aligned_a) drops++;
      end
    end
    check("loop_aligned_drops", 32'(drops), 0);

    // Enable toggling: lock after 8 enabled tokens, disabled cycles carry data symbols.
    reset_a = 1'b1;
    step_a(10'b0100000000, 1'b1);
    reset_a = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step_a((k % 2 == 0) ? tok[0] : 10'b0100000001, k % 2 == 0);
      if (k == 15) check("toggle_not_yet", 32'(aligned_a), 0);
      if (k == 16) check("toggle_locked", 32'(aligned_a), 1);
      if (k % 2 == 1) check("toggle_slip_low", 32'(slip_a), 0);
    end
    en_a = 1'b0;

    // Run completing as the search window expires: run wins.
    reset_b = 1'b0;
    slips = 0;
    for (int k = 1; k <= 64; k++) begin
      step_b((k <= 56) ? 10'b0100000000 : tok[0], 1'b1);
      if (slip_b) slips++;
    end
    check("tie_aligned", 32'(aligned_b), 1);
    check("tie_slips", 32'(slips), 0);

    // Rotated stream: slip every 64+4 words, lock after third slip.
    reset_b = 1'b1;
    step_b(10'b0100000000, 1'b1);
    reset_b = 1'b0;
    r = 3; slips = 0; lockw = 0;
    sw[0] = 0; sw[1] = 0; sw[2] = 0;
    for (int w = 1; w <= 400; w++) begin
      step_b(rotl(tok[0], r), 1'b1);
      if (slip_b) begin
        if (slips < 3) sw[slips] = w;
        slips++;
        if (r > 0) r--;
      end
      if (aligned_b) begin
        lockw = w;
        break;
      end
    end
    check("rot_slips", 32'(slips), 3);
    check("rot_slip1", 32'(sw[0]), 64);
    check("rot_slip2", 32'(sw[1]), 132);
    check("rot_slip3", 32'(sw[2]), 200);
    check("rot_lock_word", 32'(lockw), 212);

    // Active video longer than the window drops lock without slipping.
    early = 0;
    for (int k = 1; k <= 64; k++) begin
      step_b(10'b0100000000, 1'b1);
      if (k < 64 && !aligned_b) early++;
    end
    check("drop_early", 32'(early), 0);
    check("drop_aligned", 32'(aligned_b), 0);
    check("drop_noslip", 32'(slip_b), 0);
    check("drop_state", 32'(dbg_b), 0);

    // Reset in SETTLE.
    for (int k = 1; k <= 64; k++) step_b(10'b0100000000, 1'b1);
    check("settle_slip", 32'(slip_b), 1);
    check("settle_state", 32'(dbg_b), 1);
    step_b(10'b0100000000, 1'b1);
    check("settle_slip_once", 32'(slip_b), 0);
    check("settle_state2", 32'(dbg_b), 1);
    reset_b = 1'b1;
    step_b(tok[0], 1'b1);
    check("rst_settle_state", 32'(dbg_b), 0);
    check("rst_settle_slip", 32'(slip_b), 0);
    check("rst_settle_aligned", 32'(aligned_b), 0);
    reset_b = 1'b0;
    en_b = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
